digit_entry: RTL and testbench

DIGIT_ENTRY -- requirements
Module: digit_entry

---
 rtl/stopwatch_pkg.sv | 35 +++
 rtl/btn_debounce.sv | 55 +++++
 rtl/digit_entry.sv | 114 +++++++++++
 tb/tb_digit_entry.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared constants and helpers for the digit entry block
//
// Purpose: FSM state encodings, debounce default, BCD limit, one-hot digit
//          select constants and the single-digit BCD step helper.
// Ports:   none (package)

package stopwatch_pkg;

  // 20 ms at 12 MHz
  localparam int DB_CNT_DEFAULT = 240000;

  localparam logic [3:0] BCD_MAX = 4'd9;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_EDIT   = 2'd1;
  localparam logic [1:0] ST_COMMIT = 2'd2;

  localparam logic [2:0] SEL_NONE     = 3'b000;
  localparam logic [2:0] SEL_UNITS    = 3'b001;
  localparam logic [2:0] SEL_TENS     = 3'b010;
  localparam logic [2:0] SEL_HUNDREDS = 3'b100;

  // One BCD digit step with wrap: up=1 gives 9->0, up=0 gives 0->9.
  function automatic logic [3:0] bcd_step(input logic [3:0] d, input logic up);
    logic [3:0] r;
    r = d;
    if (up) begin
      r = (d >= BCD_MAX) ? 4'd0 : d + 4'd1;
    end else begin
      r = (d == 4'd0) ? BCD_MAX : d - 4'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - button synchronizer, debouncer and press-event pulse
//
// Purpose: brings an active-low asynchronous push-button into the clk domain,
//          filters bounce shorter than DB_CNT cycles and emits a one-cycle
//          pulse when the debounced level falls (press). Release is silent.
// Ports:   clk   - system clock
//          rst   - asynchronous active-high reset
//          btn   - raw active-low button
//          press - one-cycle press event

module btn_debounce
  import stopwatch_pkg::*;
#(
  parameter int DB_CNT = DB_CNT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  localparam int CW = (DB_CNT > 1) ? $clog2(DB_CNT) : 1;

  logic          sync1;
  logic          sync2;
  logic          stable;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1  <= 1'b1;
      sync2  <= 1'b1;
      stable <= 1'b1;
      cnt    <= '0;
      press  <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 != stable) begin
        if (cnt == CW'(DB_CNT - 1)) begin
          stable <= sync2;
          cnt    <= '0;
          // Pulse coincides with the stable level falling.
          press  <= ~sync2;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/digit_entry.sv
// rtl/digit_entry.sv - three-digit BCD entry with set/sel/inc buttons and commit
//
// Purpose: set enters edit mode, sel rotates the selected digit, inc steps the
//          selected digit up or down (dir), a second set commits the BCD
//          digits as a binary value with a one-cycle load strobe.
// Ports:   clk       - system clock (12 MHz)
//          rst       - asynchronous active-high reset
//          btn_set   - raw active-low set button
//          btn_sel   - raw active-low select button
//          btn_inc   - raw active-low step button
//          dir       - 1 increment, 0 decrement
//          bcd       - digits being edited {hundreds, tens, units}
//          digit_sel - one-hot selected digit, 000 when not editing
//          editing   - high in EDIT
//          value     - committed binary value 0..999
//          load      - one-cycle strobe when value updates

module digit_entry
  import stopwatch_pkg::*;
#(
  parameter int DB_CNT = DB_CNT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_set,
  input  logic        btn_sel,
  input  logic        btn_inc,
  input  logic        dir,
  output logic [11:0] bcd,
  output logic [2:0]  digit_sel,
  output logic        editing,
  output logic [9:0]  value,
  output logic        load
);

  logic       set_ev;
  logic       sel_ev;
  logic       inc_ev;
  logic [1:0] state;
  logic [9:0] bin_value;

  btn_debounce #(.DB_CNT(DB_CNT)) u_db_set (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_set),
    .press (set_ev)
  );

  btn_debounce #(.DB_CNT(DB_CNT)) u_db_sel (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_sel),
    .press (sel_ev)
  );

  btn_debounce #(.DB_CNT(DB_CNT)) u_db_inc (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_inc),
    .press (inc_ev)
  );

  // All terms are 10 bits wide so 999 is exact.
  assign bin_value = ({6'd0, bcd[11:8]} * 10'd100)
                   + ({6'd0, bcd[7:4]}  * 10'd10)
                   +  {6'd0, bcd[3:0]};

  assign editing = (state == ST_EDIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      bcd       <= 12'h000;
      digit_sel <= SEL_NONE;
      value     <= 10'd0;
      load      <= 1'b0;
    end else begin
      load <= 1'b0;
      case (state)
        ST_IDLE: begin
          digit_sel <= SEL_NONE;
          if (set_ev) begin
            state     <= ST_EDIT;
            digit_sel <= SEL_UNITS;
          end
        end
        ST_EDIT: begin
          // Priority set > sel > inc; only the highest event acts.
          if (set_ev) begin
            state     <= ST_COMMIT;
            digit_sel <= SEL_NONE;
          end else if (sel_ev) begin
            digit_sel <= {digit_sel[1:0], digit_sel[2]};
          end else if (inc_ev) begin
            if (digit_sel[0]) bcd[3:0]  <= bcd_step(bcd[3:0], dir);
            if (digit_sel[1]) bcd[7:4]  <= bcd_step(bcd[7:4], dir);
            if (digit_sel[2]) bcd[11:8] <= bcd_step(bcd[11:8], dir);
          end
        end
        ST_COMMIT: begin
          value     <= bin_value;
          load      <= 1'b1;
          state     <= ST_IDLE;
          digit_sel <= SEL_NONE;
        end
        default: begin
          state     <= ST_IDLE;
          digit_sel <= SEL_NONE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_digit_entry.sv
// tb/tb_digit_entry.sv - self-checking bench for digit_entry with DB_CNT=4

module tb_digit_entry;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        btn_set = 1'b1;
  logic        btn_sel = 1'b1;
  logic        btn_inc = 1'b1;
  logic        dir = 1'b1;
  logic [11:0] bcd;
  logic [2:0]  digit_sel;
  logic        editing;
  logic [9:0]  value;
  logic        load;

  digit_entry #(.DB_CNT(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_set   (btn_set),
    .btn_sel   (btn_sel),
    .btn_inc   (btn_inc),
    .dir       (dir),
    .bcd       (bcd),
    .digit_sel (digit_sel),
    .editing   (editing),
    .value     (value),
    .load      (load)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Cycle counter and load monitor.
  int         cyc = 0;
  int         load_cnt = 0;
  int         load_cyc = -1;
  logic [9:0] load_val = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (load === 1'b1) begin
      load_cnt <= load_cnt + 1;
      load_cyc <= cyc;
      load_val <= value;
    end
  end

  // Reference model: digits as integers, selected position index 0..2.
  int m_d[3];
  int m_sel = 0;
  bit m_edit = 0;
  int m_value = 0;
  int exp_loads = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] model_bcd();
    return {4'(m_d[2]), 4'(m_d[1]), 4'(m_d[0])};
  endfunction

  task automatic check_outputs(input string tag);
    check({tag, ".bcd"}, {20'd0, bcd}, {20'd0, model_bcd()});
    check({tag, ".digit_sel"}, {29'd0, digit_sel}, m_edit ? (32'd1 << m_sel) : 32'd0);
    check({tag, ".editing"}, {31'd0, editing}, {31'd0, m_edit});
    check({tag, ".value"}, {22'd0, value}, m_value);
    check({tag, ".load_count"}, load_cnt, exp_loads);
    check({tag, ".load_idle"}, {31'd0, load}, 32'd0);
  endtask

  task automatic model_update(input bit s, input bit l, input bit i, input bit d);
    if (s) begin
      if (!m_edit) begin
        m_edit = 1;
        m_sel = 0;
      end else begin
        m_value = 100 * m_d[2] + 10 * m_d[1] + m_d[0];
        exp_loads++;
        m_edit = 0;
      end
    end else if (m_edit && l) begin
      m_sel = (m_sel + 1) % 3;
    end else if (m_edit && i) begin
      m_d[m_sel] = d ? (m_d[m_sel] + 1) % 10 : (m_d[m_sel] + 9) % 10;
    end
  endtask

  // Hold the chosen buttons low long enough to debounce, then release.
  // Event lands 6 edges after the drive (2 sync + 4 debounce); load 2 later.
  task automatic do_press(input bit s, input bit l, input bit i, input bit d);
    int t0;
    bit commits;
    @(negedge clk);
    commits = s && m_edit;
    dir = d;
    btn_set = !s;
    btn_sel = !l;
    btn_inc = !i;
    t0 = cyc;
    repeat (12) @(negedge clk);
    btn_set = 1'b1;
    btn_sel = 1'b1;
    btn_inc = 1'b1;
    repeat (12) @(negedge clk);
    model_update(s, l, i, d);
    if (commits) begin
      check("load_time", load_cyc - t0, 32'd8);
      check("load_value", {22'd0, load_val}, m_value);
    end
    check_outputs("press");
  endtask

  // Bounce shorter than the debounce period must do nothing.
  task automatic glitch(input int which, input int len);
    @(negedge clk);
    if (which == 0) btn_set = 1'b0;
    else if (which == 1) btn_sel = 1'b0;
    else btn_inc = 1'b0;
    repeat (len) @(negedge clk);
    btn_set = 1'b1;
    btn_sel = 1'b1;
    btn_inc = 1'b1;
    repeat (10) @(negedge clk);
    check_outputs("glitch");
  endtask

  task automatic goto_digits(input int h, input int t, input int u);
    int tgt[3];
    tgt[0] = u;
    tgt[1] = t;
    tgt[2] = h;
    for (int p = 0; p < 3; p++) begin
      while (m_sel != p) do_press(0, 1, 0, 1);
      while (m_d[p] != tgt[p]) do_press(0, 0, 1, 1);
    end
  endtask

  initial begin
    int r;
    int loads_before;
    m_d[0] = 0;
    m_d[1] = 0;
    m_d[2] = 0;

    // Reset state
    repeat (3) @(negedge clk);
    check_outputs("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Short set bounces: no event
    glitch(0, 3);
    glitch(0, 1);

    // Directed entry of 183
    do_press(1, 0, 0, 1);
    repeat (3) do_press(0, 0, 1, 1);
    do_press(0, 1, 0, 1);
    repeat (2) do_press(0, 0, 1, 0);
    do_press(0, 1, 0, 1);
    do_press(0, 0, 1, 1);
    check("bcd_183", {20'd0, bcd}, 32'h183);
    do_press(1, 0, 0, 1);
    check("value_183", {22'd0, value}, 32'd183);

    // Units wrap both ways, other digits untouched
    do_press(1, 0, 0, 1);
    goto_digits(1, 8, 9);
    while (m_sel != 0) do_press(0, 1, 0, 1);
    do_press(0, 0, 1, 1);
    check("wrap_up", {20'd0, bcd}, 32'h180);
    do_press(0, 0, 1, 0);
    check("wrap_down", {20'd0, bcd}, 32'h189);

    // Commit boundaries 999 and 000
    goto_digits(9, 9, 9);
    do_press(1, 0, 0, 1);
    check("value_999", {22'd0, value}, 32'd999);
    do_press(1, 0, 0, 1);
    goto_digits(0, 0, 0);
    loads_before = load_cnt;
    do_press(1, 0, 0, 1);
    check("value_0", {22'd0, value}, 32'd0);
    check("load_0_present", load_cnt - loads_before, 32'd1);

    // set + inc together in EDIT: commit wins, bcd unchanged
    do_press(1, 0, 0, 1);
    goto_digits(2, 3, 4);
    do_press(1, 0, 1, 1);
    check("set_inc_bcd", {20'd0, bcd}, 32'h234);

    // Randomized presses and bounces
    for (int k = 0; k < 60; k++) begin
      r = $urandom_range(0, 9);
      if (r == 0) glitch($urandom_range(0, 2), $urandom_range(1, 3));
      else if (r == 1) do_press(1, 0, 0, 1);
      else if (r <= 4) do_press(0, 1, 0, 1);
      else if (r <= 8) do_press(0, 0, 1, 1'($urandom_range(0, 1)));
      else do_press(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // Reset while editing 456 aborts the entry
    if (!m_edit) do_press(1, 0, 0, 1);
    goto_digits(4, 5, 6);
    check("bcd_456", {20'd0, bcd}, 32'h456);
    loads_before = load_cnt;
    @(negedge clk);
    rst = 1'b1;
    #1;
    m_d[0] = 0;
    m_d[1] = 0;
    m_d[2] = 0;
    m_sel = 0;
    m_edit = 0;
    m_value = 0;
    check("rst_bcd", {20'd0, bcd}, 32'd0);
    check("rst_value", {22'd0, value}, 32'd0);
    check("rst_editing", {31'd0, editing}, 32'd0);
    check("rst_digit_sel", {29'd0, digit_sel}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_no_load", load_cnt - loads_before, 32'd0);
    exp_loads = load_cnt;
    glitch(0, 3);
    do_press(1, 0, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
